// File: rtl/data_mem_arbiter.sv
// Single-port DataMemory controller shared by the MEM stage and the SAD window-fetch engine.
// Partial stores become a read-modify-write pair; a starved secondary is eventually forced in.
module data_mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        p_req,
  input  logic        p_we,
  input  logic [1:0]  p_size,
  input  logic [31:0] p_addr,
  input  logic [31:0] p_wdata,
  output logic [31:0] p_rdata,
  output logic        p_stall,
  input  logic        s_req,
  input  logic        s_we,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_wdata,
  output logic        s_gnt,
  output logic [31:0] s_rdata,
  output logic        s_rvalid,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] MemRData
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  typedef enum logic [0:0] {StIdle, StRmwWr} state_t;

  state_t          state_q, state_d;
  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     merged_q, merged_d;
  logic [31:0]     s_rdata_d;
  logic            s_rvalid_d;

  logic p_partial;
  logic s_slot;
  logic p_rmw;
  logic unused_s_addr_lsbs;

  // Secondary addresses are always word aligned.
  assign unused_s_addr_lsbs = ^s_addr[1:0];

  assign p_partial = (p_size == 2'b01) || (p_size == 2'b10);
  assign s_slot    = (state_q == StIdle) && s_req && (!p_req || (starve_cnt_q == StarveMax));
  assign p_rmw     = (state_q == StIdle) && p_req && !s_slot && p_we && p_partial;

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (p_rmw) state_d = StRmwWr;
      StRmwWr: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic; reset forces every combinational output low.
  always_comb begin
    MemAddr  = 32'h0;
    MemWData = 32'h0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    p_stall  = 1'b0;
    s_gnt    = 1'b0;
    if (!Rst) begin
      unique case (state_q)
        StIdle: begin
          if (s_slot) begin
            s_gnt    = 1'b1;
            p_stall  = p_req;
            MemAddr  = {s_addr[31:2], 2'b00};
            MemWData = s_wdata;
            MemWrite = s_we;
            MemRead  = !s_we;
          end else if (p_rmw) begin
            p_stall  = 1'b1;
            MemAddr  = {p_addr[31:2], 2'b00};
            MemRead  = 1'b1;
          end else if (p_req) begin
            MemAddr  = {p_addr[31:2], 2'b00};
            MemWData = p_wdata;
            MemWrite = p_we;
            MemRead  = !p_we;
          end
        end
        StRmwWr: begin
          MemAddr  = addr_q;
          MemWData = merged_q;
          MemWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign p_rdata = (!Rst && !p_stall) ? MemRData : 32'h0;

  // Lane merge for partial stores (little-endian; half lane ignores addr[0]).
  always_comb begin
    merged_d = MemRData;
    if (p_size == 2'b10) begin
      unique case (p_addr[1:0])
        2'd0: merged_d[7:0]   = p_wdata[7:0];
        2'd1: merged_d[15:8]  = p_wdata[7:0];
        2'd2: merged_d[23:16] = p_wdata[7:0];
        2'd3: merged_d[31:24] = p_wdata[7:0];
        default: ;
      endcase
    end else if (p_addr[1]) begin
      merged_d[31:16] = p_wdata[15:0];
    end else begin
      merged_d[15:0] = p_wdata[15:0];
    end
  end

  assign addr_d = {p_addr[31:2], 2'b00};

  always_comb begin
    starve_cnt_d = '0;
    if (s_slot) begin
      starve_cnt_d = '0;
    end else if (s_req) begin
      starve_cnt_d = (starve_cnt_q == StarveMax) ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
  end

  assign s_rvalid_d = s_slot && !s_we;
  assign s_rdata_d  = s_rvalid_d ? MemRData : s_rdata;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      starve_cnt_q <= '0;
      addr_q       <= 32'h0;
      merged_q     <= 32'h0;
      s_rdata      <= 32'h0;
      s_rvalid     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      s_rdata      <= s_rdata_d;
      s_rvalid     <= s_rvalid_d;
      if (p_rmw) begin
        addr_q   <= addr_d;
        merged_q <= merged_d;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small combinational-read word memory model.
module tb_data_mem_arbiter;

  logic        Clk;
  logic        Rst;
  logic        p_req, p_we;
  logic [1:0]  p_size;
  logic [31:0] p_addr, p_wdata, p_rdata;
  logic        p_stall;
  logic        s_req, s_we;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_gnt, s_rvalid;
  logic [31:0] MemAddr, MemWData, MemRData;
  logic        MemWrite, MemRead;

  int passed;
  int total;

  logic [31:0] mem [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;

  data_mem_arbiter #(.STARVE_MAX(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .p_req(p_req), .p_we(p_we), .p_size(p_size), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_stall(p_stall),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemWrite(MemWrite), .MemRead(MemRead),
    .MemRData(MemRData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign MemRData = mem[MemAddr[7:2]];
  always @(posedge Clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (MemWrite) mem[MemAddr[7:2]] <= MemWData;
  end

  task automatic idle_inputs();
    p_req = 0; p_we = 0; p_size = 0; p_addr = 0; p_wdata = 0;
    s_req = 0; s_we = 0; s_addr = 0; s_wdata = 0;
  endtask

  task automatic preload(input logic [31:0] byte_addr, input logic [31:0] data);
    idle_inputs();
    pl_en = 1; pl_idx = byte_addr[7:2]; pl_data = data;
    @(negedge Clk);
    pl_en = 0;
  endtask

  task automatic test_reset();
    Rst = 1;
    p_req = 1; p_we = 1; p_addr = 32'h10; p_wdata = 32'h12345678;
    #1;
    total++; if (MemWrite !== 1'b0) $display("FAIL reset_memwrite got %b want 0", MemWrite); else passed++;
    total++; if (MemAddr !== 32'h0) $display("FAIL reset_memaddr got %h want 0", MemAddr); else passed++;
    total++; if (s_rvalid !== 1'b0 || s_rdata !== 32'h0) $display("FAIL reset_sregs got %b/%h want 0/0", s_rvalid, s_rdata); else passed++;
    @(negedge Clk);
    idle_inputs();
    Rst = 0;
    #1;
    total++; if ({MemWrite, MemRead, MemAddr, MemWData} !== 66'h0) $display("FAIL idle_mem got %b%b %h %h want all 0", MemWrite, MemRead, MemAddr, MemWData); else passed++;
    @(negedge Clk);
  endtask

  task automatic test_word();
    p_req = 1; p_we = 1; p_size = 2'b00; p_addr = 32'h10; p_wdata = 32'hDEADBEEF;
    #1;
    total++; if (MemWrite !== 1'b1 || p_stall !== 1'b0) $display("FAIL word_store got we=%b stall=%b want 1/0", MemWrite, p_stall); else passed++;
    total++; if (MemWData !== 32'hDEADBEEF) $display("FAIL word_wdata got %h want deadbeef", MemWData); else passed++;
    @(negedge Clk);
    p_we = 0; p_wdata = 0;
    #1;
    total++; if (p_rdata !== 32'hDEADBEEF || MemRead !== 1'b1) $display("FAIL word_load got %h rd=%b want deadbeef/1", p_rdata, MemRead); else passed++;
    @(negedge Clk);
    idle_inputs();
    @(negedge Clk);
  endtask

  // Runs a partial store to completion and checks both phases plus the final word.
  task automatic do_partial(input string nm, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp);
    preload(32'h10, 32'h11223344);
    p_req = 1; p_we = 1; p_size = sz; p_addr = a; p_wdata = wd;
    #1;
    total++; if (MemRead !== 1'b1 || p_stall !== 1'b1 || MemWrite !== 1'b0) $display("FAIL %s_c0 got rd=%b stall=%b we=%b want 1/1/0", nm, MemRead, p_stall, MemWrite); else passed++;
    @(negedge Clk);
    #1;
    total++; if (MemWrite !== 1'b1 || p_stall !== 1'b0 || MemAddr !== 32'h10) $display("FAIL %s_c1 got we=%b stall=%b addr=%h want 1/0/10", nm, MemWrite, p_stall, MemAddr); else passed++;
    total++; if (MemWData !== exp) $display("FAIL %s_merge got %h want %h", nm, MemWData, exp); else passed++;
    @(negedge Clk);
    idle_inputs();
    #1;
    total++; if (mem[4] !== exp) $display("FAIL %s_mem got %h want %h", nm, mem[4], exp); else passed++;
    @(negedge Clk);
  endtask

  task automatic test_partial();
    do_partial("byte11", 2'b10, 32'h11, 32'h000000AB, 32'h1122AB44);
    do_partial("byte13", 2'b10, 32'h13, 32'h123456CD, 32'hCD223344);
    do_partial("half12", 2'b01, 32'h12, 32'h0000BEEF, 32'hBEEF3344);
    do_partial("half13", 2'b01, 32'h13, 32'h0000BEEF, 32'hBEEF3344);
    do_partial("half10", 2'b01, 32'h10, 32'hFFFFBEEF, 32'h1122BEEF);
  endtask

  task automatic test_secondary();
    preload(32'h10, 32'h11223344);
    s_req = 1; s_we = 0; s_addr = 32'h13;
    #1;
    total++; if (s_gnt !== 1'b1 || MemRead !== 1'b1 || MemAddr !== 32'h10) $display("FAIL sec_rd_c0 got gnt=%b rd=%b addr=%h want 1/1/10", s_gnt, MemRead, MemAddr); else passed++;
    @(negedge Clk);
    idle_inputs();
    #1;
    total++; if (s_rvalid !== 1'b1 || s_rdata !== 32'h11223344) $display("FAIL sec_rd_c1 got v=%b d=%h want 1/11223344", s_rvalid, s_rdata); else passed++;
    @(negedge Clk);
    s_req = 1; s_we = 1; s_addr = 32'h22; s_wdata = 32'h0BADF00D;
    #1;
    total++; if (s_gnt !== 1'b1 || MemWrite !== 1'b1 || MemAddr !== 32'h20) $display("FAIL sec_wr got gnt=%b we=%b addr=%h want 1/1/20", s_gnt, MemWrite, MemAddr); else passed++;
    @(negedge Clk);
    idle_inputs();
    p_req = 1; p_addr = 32'h20;
    #1;
    total++; if (s_rvalid !== 1'b0) $display("FAIL sec_wr_rvalid got %b want 0", s_rvalid); else passed++;
    total++; if (p_rdata !== 32'h0BADF00D) $display("FAIL sec_wr_mem got %h want 0badf00d", p_rdata); else passed++;
    @(negedge Clk);
    idle_inputs();
    @(negedge Clk);
  endtask

  task automatic test_starve();
    preload(32'h10, 32'h11223344);
    p_req = 1; p_we = 0; p_addr = 32'h20;
    s_req = 1; s_we = 0; s_addr = 32'h10;
    for (int c = 0; c < 10; c++) begin
      logic exp_g;
      exp_g = (c == 4) || (c == 9);
      #1;
      total++; if (s_gnt !== exp_g || p_stall !== exp_g) $display("FAIL starve_c%0d got gnt=%b stall=%b want %b", c, s_gnt, p_stall, exp_g); else passed++;
      if (exp_g) begin
        total++; if (p_rdata !== 32'h0) $display("FAIL starve_prdata_c%0d got %h want 0", c, p_rdata); else passed++;
      end
      @(negedge Clk);
    end
    idle_inputs();
    @(negedge Clk);
  endtask

  task automatic test_starve_rmw();
    preload(32'h10, 32'h11223344);
    preload(32'h40, 32'hCAFEF00D);
    p_req = 1; p_we = 0; p_addr = 32'h20;
    s_req = 1; s_we = 0; s_addr = 32'h40;
    for (int c = 0; c < 4; c++) @(negedge Clk);
    p_we = 1; p_size = 2'b10; p_addr = 32'h11; p_wdata = 32'h55;
    #1;
    total++; if (s_gnt !== 1'b1 || p_stall !== 1'b1 || MemAddr !== 32'h40 || MemRead !== 1'b1) $display("FAIL srmw_c0 got gnt=%b stall=%b addr=%h want 1/1/40", s_gnt, p_stall, MemAddr); else passed++;
    @(negedge Clk);
    s_req = 0;
    #1;
    total++; if (s_rvalid !== 1'b1 || s_rdata !== 32'hCAFEF00D) $display("FAIL srmw_sdata got v=%b d=%h want 1/cafef00d", s_rvalid, s_rdata); else passed++;
    total++; if (s_gnt !== 1'b0 || p_stall !== 1'b1 || MemAddr !== 32'h10 || MemWrite !== 1'b0) $display("FAIL srmw_c1 got gnt=%b stall=%b addr=%h we=%b want 0/1/10/0", s_gnt, p_stall, MemAddr, MemWrite); else passed++;
    @(negedge Clk);
    #1;
    total++; if (MemWrite !== 1'b1 || MemWData !== 32'h11225544 || p_stall !== 1'b0) $display("FAIL srmw_c2 got we=%b wd=%h stall=%b want 1/11225544/0", MemWrite, MemWData, p_stall); else passed++;
    @(negedge Clk);
    idle_inputs();
    @(negedge Clk);
  endtask

  task automatic test_reset_mid_rmw();
    preload(32'h10, 32'h11223344);
    p_req = 1; p_we = 1; p_size = 2'b10; p_addr = 32'h11; p_wdata = 32'hAB;
    @(negedge Clk);
    Rst = 1;
    #1;
    total++; if (MemWrite !== 1'b0 || MemAddr !== 32'h0 || MemWData !== 32'h0) $display("FAIL rstrmw_mem got we=%b addr=%h wd=%h want 0/0/0", MemWrite, MemAddr, MemWData); else passed++;
    total++; if (p_stall !== 1'b0 || p_rdata !== 32'h0 || s_gnt !== 1'b0) $display("FAIL rstrmw_out got stall=%b rd=%h gnt=%b want 0/0/0", p_stall, p_rdata, s_gnt); else passed++;
    @(negedge Clk);
    idle_inputs();
    Rst = 0;
    #1;
    total++; if (mem[4] !== 32'h11223344) $display("FAIL rstrmw_memval got %h want 11223344", mem[4]); else passed++;
    total++; if (MemWrite !== 1'b0) $display("FAIL rstrmw_state got we=%b want 0", MemWrite); else passed++;
    @(negedge Clk);
    p_req = 1; p_addr = 32'h10;
    #1;
    total++; if (p_stall !== 1'b0 || p_rdata !== 32'h11223344) $display("FAIL rstrmw_load got stall=%b rd=%h want 0/11223344", p_stall, p_rdata); else passed++;
    @(negedge Clk);
    idle_inputs();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    pl_en = 0; pl_idx = 0; pl_data = 0;
    idle_inputs();
    Rst = 1;
    @(negedge Clk);
    test_reset();
    test_word();
    test_partial();
    test_secondary();
    test_starve();
    test_starve_rmw();
    test_reset_mid_rmw();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
